// File: rtl/game_timer_if.sv
// rtl/game_timer_if.sv - control and status bundle between the game FSM and game_timer
// TIMER_BONUS_EN adds the add_time control.
interface game_timer_if;
   logic       start;
   logic       pause;
`ifdef TIMER_BONUS_EN
   logic       add_time;
`endif
   logic [6:0] seconds;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       sec_tick;
   logic       running;
   logic       warning;
   logic       game_over;

`ifdef TIMER_BONUS_EN
   modport master (
      output start, pause, add_time,
      input  seconds, sec_tens, sec_ones, sec_tick, running, warning, game_over
   );
   modport slave (
      input  start, pause, add_time,
      output seconds, sec_tens, sec_ones, sec_tick, running, warning, game_over
   );
`else
   modport master (
      output start, pause,
      input  seconds, sec_tens, sec_ones, sec_tick, running, warning, game_over
   );
   modport slave (
      input  start, pause,
      output seconds, sec_tens, sec_ones, sec_tick, running, warning, game_over
   );
`endif
endinterface

// File: rtl/game_timer.sv
// rtl/game_timer.sv - whole-second round countdown with pause, low-time warning, BCD digits, game over
// TIMER_BONUS_EN enables the add_time bonus path (BONUS_SEC, MAX_SEC).
module game_timer #(
   parameter int CYCLES_PER_SEC = 100_000_000,
   parameter int START_SEC      = 30,
`ifdef TIMER_BONUS_EN
   parameter int BONUS_SEC      = 3,
   parameter int MAX_SEC        = 99,
`endif
   parameter int WARN_SEC       = 5
) (
   input  logic        clk,
   input  logic        rst,
   game_timer_if.slave bus
);
   localparam int             PW         = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(CYCLES_PER_SEC - 1);
   localparam logic [6:0]     START_VAL  = 7'(START_SEC);
   localparam logic [3:0]     START_TENS = 4'(START_SEC / 10);
   localparam logic [3:0]     START_ONES = 4'(START_SEC % 10);
   localparam logic [6:0]     WARN_VAL   = 7'(WARN_SEC);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [6:0]    sec_q, sec_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic          tick_q, tick_d;
   logic          running_q, running_d;
   logic          warning_q, warning_d;
   logic          over_q, over_d;
   logic          live;
`ifdef TIMER_BONUS_EN
   logic [7:0]    bonus_sum;
`endif

   assign live = (state_q == RUN) || (state_q == PAUSED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         sec_q     <= START_VAL;
         tens_q    <= START_TENS;
         ones_q    <= START_ONES;
         tick_q    <= 1'b0;
         running_q <= 1'b0;
         warning_q <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         sec_q     <= sec_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         tick_q    <= tick_d;
         running_q <= running_d;
         warning_q <= warning_d;
         over_q    <= over_d;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      sec_d   = sec_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      tick_d  = 1'b0;
`ifdef TIMER_BONUS_EN
      bonus_sum = '0;
`endif
      if (bus.start) begin
         presc_d = '0;
         sec_d   = START_VAL;
         tens_d  = START_TENS;
         ones_d  = START_ONES;
         state_d = (START_SEC == 0) ? OVER : RUN;
      end else begin
         // The prescaler only advances in RUN cycles without pause, so a pause never loses a partial second.
         case (state_q)
            RUN: begin
               if (bus.pause) begin
                  state_d = PAUSED;
               end else if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  tick_d  = (sec_q != 7'd0);
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            PAUSED: begin
               if (!bus.pause) state_d = RUN;
            end
            default: ;
         endcase

         if (tick_d) begin
            sec_d = sec_q - 7'd1;
            if (ones_q == 4'd0) begin
               ones_d = 4'd9;
               tens_d = tens_q - 4'd1;
            end else begin
               ones_d = ones_q - 4'd1;
            end
         end

`ifdef TIMER_BONUS_EN
         if (bus.add_time && live) begin
            bonus_sum = {1'b0, sec_q} + 8'(BONUS_SEC) - {7'd0, tick_d};
            sec_d     = (bonus_sum > 8'(MAX_SEC)) ? 7'(MAX_SEC) : bonus_sum[6:0];
            tens_d    = 4'(sec_d / 7'd10);
            ones_d    = 4'(sec_d % 7'd10);
         end
`endif

         if (live && (sec_d == 7'd0)) state_d = OVER;
      end

      running_d = (state_d == RUN) || (state_d == PAUSED);
      warning_d = running_d && (sec_d != 7'd0) && (sec_d <= WARN_VAL);
      over_d    = (state_d == OVER);
   end

   assign bus.seconds   = sec_q;
   assign bus.sec_tens  = tens_q;
   assign bus.sec_ones  = ones_q;
   assign bus.sec_tick  = tick_q;
   assign bus.running   = running_q;
   assign bus.warning   = warning_q;
   assign bus.game_over = over_q;
endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - randomized self-checking bench for game_timer against a per-cycle behavioural model
`timescale 1ns/1ps
module tb_game_timer;
   localparam int CPS   = 10;
   localparam int START = 30;
   localparam int WARN  = 5;
   localparam int BONUS = 3;
   localparam int MAXS  = 99;
`ifdef TIMER_BONUS_EN
   localparam bit BONUS_EN = 1'b1;
`else
   localparam bit BONUS_EN = 1'b0;
`endif
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_OVER = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   game_timer_if bus ();

   game_timer #(
      .CYCLES_PER_SEC(CPS),
      .START_SEC(START),
`ifdef TIMER_BONUS_EN
      .BONUS_SEC(BONUS),
      .MAX_SEC(MAXS),
`endif
      .WARN_SEC(WARN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int tests_run = 0;
   int failed    = 0;

   // Model: game mode, remaining seconds, and run cycles spent in the current second.
   int m_mode    = M_IDLE;
   int m_sec     = START;
   int m_elapsed = 0;
   bit m_tick    = 1'b0;

   task automatic model(input bit st, input bit pa, input bit ad, input bit rs);
      bit counting;
      int next;
      m_tick = 1'b0;
      if (rs) begin
         m_mode = M_IDLE; m_sec = START; m_elapsed = 0;
      end else if (st) begin
         m_sec = START; m_elapsed = 0;
         m_mode = (START == 0) ? M_OVER : M_RUN;
      end else if (m_mode == M_RUN || m_mode == M_PAUSED) begin
         counting = (m_mode == M_RUN) && !pa;
         m_mode = pa ? M_PAUSED : M_RUN;
         if (counting) begin
            m_elapsed++;
            if (m_elapsed == CPS) begin
               m_elapsed = 0;
               m_tick = 1'b1;
            end
         end
         next = m_sec - int'(m_tick);
         if (BONUS_EN && ad) next = (next + BONUS > MAXS) ? MAXS : next + BONUS;
         m_sec = next;
         if (m_sec == 0) m_mode = M_OVER;
      end
   endtask

   function automatic logic [18:0] exp_vec();
      logic run_e;
      run_e = (m_mode == M_RUN) || (m_mode == M_PAUSED);
      return {7'(m_sec), 4'(m_sec / 10), 4'(m_sec % 10), m_tick, run_e,
              run_e && (m_sec > 0) && (m_sec <= WARN), (m_mode == M_OVER)};
   endfunction

   function automatic logic [18:0] dut_vec();
      return {bus.seconds, bus.sec_tens, bus.sec_ones, bus.sec_tick,
              bus.running, bus.warning, bus.game_over};
   endfunction

   task automatic step(input bit st, input bit pa, input bit ad, input bit rs);
      rst = rs;
      bus.start = st;
      bus.pause = pa;
`ifdef TIMER_BONUS_EN
      bus.add_time = ad;
`endif
      @(posedge clk);
      model(st, pa, ad, rs);
      #1;
   endtask

   task automatic test_reset;
      step(0, 0, 0, 1);
      step(0, 1, 0, 1);
      if (dut_vec() !== exp_vec()) begin
         failed++; $display("FAIL reset_status: got %h want %h", dut_vec(), exp_vec());
      end
      tests_run++;
      if ({bus.seconds, bus.sec_tens, bus.sec_ones, bus.sec_tick, bus.running, bus.warning, bus.game_over}
          !== {7'd30, 4'd3, 4'd0, 4'b0000}) begin
         failed++; $display("FAIL reset_values: got sec=%0d run=%b over=%b want 30/0/0",
                            bus.seconds, bus.running, bus.game_over);
      end
      tests_run++;
   endtask

   task automatic test_first_tick;
      int ticks = 0;
      step(1, 0, 0, 0);
      if ({bus.seconds, bus.sec_tens, bus.sec_ones, bus.running} !== {7'd30, 4'd3, 4'd0, 1'b1}) begin
         failed++; $display("FAIL start_load: got sec=%0d %0d%0d run=%b want 30 30 1",
                            bus.seconds, bus.sec_tens, bus.sec_ones, bus.running);
      end
      tests_run++;
      for (int i = 0; i < CPS; i++) begin
         step(0, 0, 0, 0);
         ticks += int'(bus.sec_tick);
         if (dut_vec() !== exp_vec()) begin
            failed++; $display("FAIL first_tick_status: got %h want %h", dut_vec(), exp_vec());
         end
         tests_run++;
      end
      if ({bus.seconds, bus.sec_tens, bus.sec_ones} !== {7'd29, 4'd2, 4'd9} || ticks != 1) begin
         failed++; $display("FAIL first_tick: got sec=%0d %0d%0d ticks=%0d want 29 29 1",
                            bus.seconds, bus.sec_tens, bus.sec_ones, ticks);
      end
      tests_run++;
   endtask

   task automatic test_run_to_end;
      int warn_rise = -1;
      int warn_gap  = 0;
      for (int n = 0; n < 40 * CPS && !bus.game_over; n++) begin
         step(0, 0, 0, 0);
         if (bus.warning && warn_rise < 0) warn_rise = int'(bus.seconds);
         if (bus.seconds >= 7'd1 && bus.seconds <= 7'd5 && !bus.warning) warn_gap++;
         if (dut_vec() !== exp_vec()) begin
            failed++; $display("FAIL run_status: got %h want %h", dut_vec(), exp_vec());
         end
         tests_run++;
      end
      if ({bus.seconds, bus.game_over, bus.running, bus.warning} !== {7'd0, 1'b1, 1'b0, 1'b0}) begin
         failed++; $display("FAIL game_over_reached: got sec=%0d over=%b run=%b want 0 1 0",
                            bus.seconds, bus.game_over, bus.running);
      end
      tests_run++;
      if (warn_rise != WARN || warn_gap != 0) begin
         failed++; $display("FAIL warning_window: got rise=%0d gaps=%0d want 5 0", warn_rise, warn_gap);
      end
      tests_run++;
      for (int i = 0; i < 50; i++) begin
         step(0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
         if (dut_vec() !== exp_vec() || bus.seconds !== 7'd0) begin
            failed++; $display("FAIL over_hold: got %h want %h", dut_vec(), exp_vec());
         end
         tests_run++;
      end
   endtask

   task automatic test_pause;
      int phase, len, sec_before, wait_n;
      for (int r = 0; r < 4; r++) begin
         phase = (r == 0) ? 4 : int'($urandom_range(0, CPS - 1));
         len   = (r == 0) ? 37 : int'($urandom_range(1, 40));
         step(1, 0, 0, 0);
         for (int n = 0; n < 2 * CPS && m_elapsed != phase; n++) step(0, 0, 0, 0);
         sec_before = int'(bus.seconds);
         for (int i = 0; i < len; i++) begin
            step(0, 1, 0, 0);
            if (dut_vec() !== exp_vec()) begin
               failed++; $display("FAIL pause_status: got %h want %h", dut_vec(), exp_vec());
            end
            tests_run++;
         end
         if (int'(bus.seconds) != sec_before || bus.running !== 1'b1) begin
            failed++; $display("FAIL pause_hold: got sec=%0d run=%b want %0d 1",
                               bus.seconds, bus.running, sec_before);
         end
         tests_run++;
         step(0, 0, 0, 0);
         wait_n = 0;
         for (int n = 0; n < 2 * CPS && !bus.sec_tick; n++) begin
            step(0, 0, 0, 0);
            wait_n++;
            if (dut_vec() !== exp_vec()) begin
               failed++; $display("FAIL resume_status: got %h want %h", dut_vec(), exp_vec());
            end
            tests_run++;
         end
         if (wait_n != CPS - phase) begin
            failed++; $display("FAIL resume_latency: got %0d cycles want %0d", wait_n, CPS - phase);
         end
         tests_run++;
      end
   endtask

   task automatic test_restart_mid;
      int wait_n = 0;
      step(1, 0, 0, 0);
      for (int n = 0; n < 40 * CPS && bus.seconds != 7'd12; n++) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      if ({bus.seconds, bus.running, bus.game_over} !== {7'd30, 1'b1, 1'b0}) begin
         failed++; $display("FAIL restart_load: got sec=%0d run=%b want 30 1", bus.seconds, bus.running);
      end
      tests_run++;
      for (int n = 0; n < 2 * CPS && !bus.sec_tick; n++) begin
         step(0, 0, 0, 0);
         wait_n++;
      end
      if (wait_n != CPS || bus.seconds !== 7'd29) begin
         failed++; $display("FAIL restart_latency: got %0d cycles sec=%0d want 10 29", wait_n, bus.seconds);
      end
      tests_run++;
      for (int n = 0; n < 40 * CPS && bus.seconds != 7'd12; n++) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      if ({bus.seconds, bus.running, bus.warning, bus.game_over} !== {7'd30, 3'b000}) begin
         failed++; $display("FAIL reset_mid_run: got sec=%0d run=%b over=%b want 30 0 0",
                            bus.seconds, bus.running, bus.game_over);
      end
      tests_run++;
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1, 0);
         if (dut_vec() !== exp_vec()) begin
            failed++; $display("FAIL idle_ignore: got %h want %h", dut_vec(), exp_vec());
         end
         tests_run++;
      end
   endtask

   task automatic test_restart_from_over;
      step(1, 0, 0, 0);
      for (int n = 0; n < 40 * CPS && !bus.game_over; n++) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      if ({bus.seconds, bus.game_over, bus.running} !== {7'd30, 1'b0, 1'b1}) begin
         failed++; $display("FAIL over_restart: got sec=%0d over=%b run=%b want 30 0 1",
                            bus.seconds, bus.game_over, bus.running);
      end
      tests_run++;
      for (int i = 0; i < CPS; i++) step(0, 0, 0, 0);
      if (bus.seconds !== 7'd29 || dut_vec() !== exp_vec()) begin
         failed++; $display("FAIL over_restart_tick: got sec=%0d want 29", bus.seconds);
      end
      tests_run++;
   endtask

   task automatic test_back_to_back;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      for (int i = 0; i < 2 * CPS; i++) begin
         step(0, 0, 0, 0);
         if (dut_vec() !== exp_vec()) begin
            failed++; $display("FAIL back_to_back: got %h want %h", dut_vec(), exp_vec());
         end
         tests_run++;
      end
   endtask

`ifdef TIMER_BONUS_EN
   task automatic test_bonus;
      step(1, 0, 0, 0);
      for (int n = 0; n < 40 * CPS && bus.seconds != 7'd28; n++) step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      if ({bus.seconds, bus.sec_tens, bus.sec_ones} !== {7'd31, 4'd3, 4'd1}) begin
         failed++; $display("FAIL bonus_28: got sec=%0d want 31", bus.seconds);
      end
      tests_run++;
      for (int n = 0; n < 40 * CPS && !(bus.seconds == 7'd1 && m_elapsed == CPS - 1); n++) step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      if ({bus.seconds, bus.game_over, bus.running} !== {7'd3, 1'b0, 1'b1}) begin
         failed++; $display("FAIL bonus_last_tick: got sec=%0d over=%b want 3 0", bus.seconds, bus.game_over);
      end
      tests_run++;
      step(0, 1, 0, 0);
      for (int n = 0; n < 40 && bus.seconds < 7'd96; n++) step(0, 1, 1, 0);
      for (int n = 0; n < 4 * CPS && bus.seconds != 7'd95; n++) step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      if (bus.seconds !== 7'd99 || dut_vec() !== exp_vec()) begin
         failed++; $display("FAIL bonus_saturate: got sec=%0d want 99", bus.seconds);
      end
      tests_run++;
   endtask
`endif

   task automatic test_random;
      bit pa = 1'b0;
      step(1, 0, 0, 0);
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 15) == 0) pa = ~pa;
         step(bit'($urandom_range(0, 149) == 0), pa, bit'($urandom_range(0, 24) == 0),
              bit'($urandom_range(0, 399) == 0));
         if (dut_vec() !== exp_vec()) begin
            failed++; $display("FAIL random_status: got %h want %h", dut_vec(), exp_vec());
         end
         tests_run++;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
`ifdef TIMER_BONUS_EN
      bus.add_time = 1'b0;
`endif
      #2;
      test_reset();
      test_first_tick();
      test_run_to_end();
      test_pause();
      test_restart_mid();
      test_restart_from_over();
      test_back_to_back();
`ifdef TIMER_BONUS_EN
      test_bonus();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
